sbox_sweep_checker: RTL and testbench
=====================================

# sbox_sweep_checker

Sequential harness stage that feeds the 6-bit S-box stage and consumes its output. On `start` it sweeps every input value `0 … 2^W-1` through the S-box, one value per cycle. It stores each response in an on-chip table and checks that the map is a permutation. It also counts fixed points and reports the first colliding input. The S-box itself stays outside this block and is wired combinationally between `sb_x` and `sb_y`, so the same checker serves every S-box variant in the family.

## Interface
- `W`, default 6: S-box width; the table has `N = 2^W` entries.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at sweep end.
- `result_valid`  out  1  high after `done`; held until the next accepted `start` or `rst`.
- `sb_x`  out  W  input driven to the S-box stage.
- `sb_y`  in  W  S-box response to `sb_x`, same cycle (combinational path).
- `is_perm`  out  1  1 when no output value repeated.
- `fixed_pts`  out  W+1  number of x with `sb_y == x`, range 0..N.
- `first_dup`  out  W  smallest x whose `sb_y` equalled an earlier output; 0 if `is_perm`.
- `rd_addr`  in  W  table read address.
- `rd_data`  out  W  `table[rd_addr]`, registered.

## Operation
- States:
  - IDLE: `sb_x` = 0. `start` → SWEEP; the same edge clears idx, `seen` mask, collision flag, `fixed_pts` and `first_dup`, and deasserts `result_valid`.
  - SWEEP: `sb_x` = idx. Each cycle:
    - write `table[idx] <= sb_y`.
    - if `seen[sb_y]` is set and collision is 0: set collision and `first_dup <= idx`.
    - set `seen[sb_y]`.
    - if `sb_y == idx`: `fixed_pts += 1`.
    - At idx = N-1 → DONE; otherwise idx += 1.
  - DONE: one cycle. `done` = 1, `result_valid` <= 1, `is_perm` <= !collision, then → IDLE.
- `start` during SWEEP or DONE is ignored; no queuing.
- Collision detection must use the `seen` state from previous cycles plus the current write. Only one write occurs per cycle, so there is no same-cycle conflict.
- `fixed_pts` cannot overflow: W+1 bits holds N.
- `is_perm`, `fixed_pts` and `first_dup` are stable whenever `result_valid` = 1.
- Table contents are not reset. `rd_data` is defined only for addresses written since reset; reads during SWEEP return current, possibly partial, contents.
- Reset values: `busy`, `done`, `result_valid`, `is_perm` = 0; `fixed_pts`, `first_dup`, `sb_x`, `rd_data` = 0; state = IDLE; idx and `seen` cleared.

## Timing
- Call the edge that samples `start` in IDLE cycle 0.
- SWEEP covers cycles 1..N; `sb_x` = k during cycle k+1.
- `done` is high in cycle N+1 (cycle 65 for W=6); `result_valid` is high from cycle N+2.
- The next `start` is accepted no earlier than cycle N+2.
- `rd_data` latency: 1 cycle after `rd_addr`.
- `rst` asserted mid-sweep aborts immediately: outputs take reset values, no `done` pulse, and the partially written table is retained.

## Structure
- Shared package `sbox_sweep_pkg` holds:
  - `W`-derived localparams `N` and `CW = W+1`.
  - State enum `{IDLE, SWEEP, DONE}`.
- Sub-module `sweep_table`: N×W storage with one synchronous write port and one registered read port; maps to distributed RAM.
- The `seen` mask, counters and FSM stay in the top level.

## Test plan
- Identity map (`sb_y = sb_x`), start at cycle 0:
  - `done` at cycle 65, `is_perm` = 1, `fixed_pts` = 64, `first_dup` = 0.
- Complement map (`sb_y = sb_x ^ 6'h3F`):
  - `is_perm` = 1, `fixed_pts` = 0.
  - `rd_addr` = 5 → `rd_data` = 6'h3A one cycle later.
- Constant map (`sb_y = 6'h2A`):
  - `is_perm` = 0, `first_dup` = 1, `fixed_pts` = 1 (x=42).
- Map `y = x` for x < 63 and `y(63) = 0`:
  - `is_perm` = 0, `first_dup` = 63, `fixed_pts` = 63.
- `start` pulsed again at cycle 10 of a sweep:
  - ignored; single `done` at cycle 65; results unchanged versus a clean run.
- `rst` asserted at cycle 30, then a new start:
  - all outputs 0 immediately, no `done` pulse.
  - New start completes with correct results and `done` 65 cycles after it.

Source files
------------

// File: rtl/sbox_sweep_pkg.sv
// Shared definitions for the S-box sweep checker: default width, derived sizes
// and the sweep controller state encoding.
package sbox_sweep_pkg;

  localparam int SB_W = 6;
  localparam int N    = 1 << SB_W;
  localparam int CW   = SB_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sweep_table.sv
// Response table: one synchronous write port, one registered read port.
// Storage has no reset so it maps onto distributed RAM; only the read register resets.
module sweep_table
  import sbox_sweep_pkg::*;
#(
  parameter int W = SB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_we,
  input  logic [W-1:0] i_wr_addr,
  input  logic [W-1:0] i_wr_data,
  input  logic [W-1:0] i_rd_addr,
  output logic [W-1:0] o_rd_data
);

  localparam int NE = 1 << W;

  logic [W-1:0] r_mem [NE];
  logic [W-1:0] r_rd_data;

  // Table write
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= {W{1'b0}};
    end else begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sbox_sweep_checker.sv
// Sweeps every S-box input once, records responses, and reports whether the map
// is a permutation, how many fixed points it has and the first colliding input.
module sbox_sweep_checker
  import sbox_sweep_pkg::*;
#(
  parameter int W = SB_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         result_valid,
  output logic [W-1:0] sb_x,
  input  logic [W-1:0] sb_y,
  output logic         is_perm,
  output logic [W:0]   fixed_pts,
  output logic [W-1:0] first_dup,
  input  logic [W-1:0] rd_addr,
  output logic [W-1:0] rd_data
);

  localparam int           NE       = 1 << W;
  localparam logic [W-1:0] IDX_LAST = W'(NE - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_idx;
  logic [NE-1:0] r_seen;
  logic          r_coll;
  logic          r_busy;
  logic          r_done;
  logic          r_result_valid;
  logic          r_is_perm;
  logic [W:0]    r_fixed_pts;
  logic [W-1:0]  r_first_dup;
  logic          w_accept;
  logic          w_sweep;
  logic          w_last;
  logic          w_hit;
  logic          w_fixed;

  assign w_hit   = r_seen[sb_y];
  assign w_fixed = (sb_y == r_idx);

  // Next-state and per-cycle control strobes
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_sweep      = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = SWEEP;
        end else begin
          w_state_next = IDLE;
        end
      end
      SWEEP: begin
        w_sweep = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_last       = 1'b1;
          w_state_next = DONE;
        end else begin
          w_state_next = SWEEP;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Sweep index, seen mask and statistics; idx wraps to 0 after the last entry
  // so sb_x reads 0 again once the sweep has finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= {W{1'b0}};
      r_seen      <= {NE{1'b0}};
      r_coll      <= 1'b0;
      r_fixed_pts <= {(W+1){1'b0}};
      r_first_dup <= {W{1'b0}};
    end else if (w_accept) begin
      r_idx       <= {W{1'b0}};
      r_seen      <= {NE{1'b0}};
      r_coll      <= 1'b0;
      r_fixed_pts <= {(W+1){1'b0}};
      r_first_dup <= {W{1'b0}};
    end else if (w_sweep) begin
      r_idx        <= r_idx + W'(1);
      r_seen[sb_y] <= 1'b1;
      if (w_hit && !r_coll) begin
        r_coll      <= 1'b1;
        r_first_dup <= r_idx;
      end
      if (w_fixed) begin
        r_fixed_pts <= r_fixed_pts + (W+1)'(1);
      end
    end
  end

  // Handshake and verdict outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_result_valid <= 1'b0;
      r_is_perm      <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_busy         <= 1'b1;
        r_result_valid <= 1'b0;
      end else if (r_state == DONE) begin
        r_busy         <= 1'b0;
        r_result_valid <= 1'b1;
        r_is_perm      <= !r_coll;
      end
    end
  end

  sweep_table #(
    .W(W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_sweep),
    .i_wr_addr (r_idx),
    .i_wr_data (sb_y),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_result_valid;
  assign sb_x         = r_idx;
  assign is_perm      = r_is_perm;
  assign fixed_pts    = r_fixed_pts;
  assign first_dup    = r_first_dup;

endmodule

// File: tb/tb_sbox_sweep_checker.sv
// Self-checking bench: the S-box is a lookup array in the bench; a timing/result
// model derived from the map is compared against the DUT on every falling edge.
module tb_sbox_sweep_checker;

  localparam int W = 6;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic         result_valid;
  logic [W-1:0] sb_x;
  logic [W-1:0] sb_y;
  logic         is_perm;
  logic [W:0]   fixed_pts;
  logic [W-1:0] first_dup;
  logic [W-1:0] rd_addr;
  logic [W-1:0] rd_data;

  logic [W-1:0] map_q [N];

  int n_checks = 0;
  int n_fail   = 0;

  // Expected results of the map currently under test
  bit p_perm;
  int p_fix;
  int p_dup;

  // Model: cycles since accepted start (-1 when idle), published results, table image
  int           m_rel = -1;
  bit           m_rv;
  bit           m_perm;
  int           m_fix;
  int           m_dup;
  logic [W-1:0] m_tbl [N];
  bit   [N-1:0] m_tval;
  int           m_rd_exp;
  bit           m_rd_valid;

  always #5 clk = ~clk;

  assign sb_y = map_q[sb_x];

  sbox_sweep_checker #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .result_valid (result_valid),
    .sb_x         (sb_x),
    .sb_y         (sb_y),
    .is_perm      (is_perm),
    .fixed_pts    (fixed_pts),
    .first_dup    (first_dup),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Permutation test, fixed-point count and first repeated input straight from the map
  task automatic eval_map(output bit perm, output int fix, output int dup);
    perm = 1'b1;
    fix  = 0;
    dup  = 0;
    for (int x = 0; x < N; x++) begin
      if (int'(map_q[x]) == x) fix++;
      if (perm) begin
        for (int j = 0; j < x; j++) begin
          if (map_q[j] == map_q[x]) begin
            perm = 1'b0;
            dup  = x;
            break;
          end
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rel      <= -1;
      m_rv       <= 1'b0;
      m_perm     <= 1'b0;
      m_fix      <= 0;
      m_dup      <= 0;
      m_rd_valid <= 1'b0;
    end else begin
      m_rd_exp   <= int'(m_tbl[rd_addr]);
      m_rd_valid <= m_tval[rd_addr];
      if (m_rel < 0) begin
        if (start) begin
          m_rel <= 0;
          m_rv  <= 1'b0;
        end
      end else if (m_rel < N) begin
        m_tbl[m_rel]  <= map_q[m_rel];
        m_tval[m_rel] <= 1'b1;
        m_rel         <= m_rel + 1;
      end else begin
        m_rel  <= -1;
        m_rv   <= 1'b1;
        m_perm <= p_perm;
        m_fix  <= p_fix;
        m_dup  <= p_dup;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, int'(m_rel >= 0));
      check("done", done, int'(m_rel == N));
      check("sb_x", sb_x, (m_rel >= 0 && m_rel < N) ? m_rel : 0);
      check("result_valid", result_valid, m_rv);
      if (m_rv) begin
        check("is_perm", is_perm, m_perm);
        check("fixed_pts", fixed_pts, m_fix);
        check("first_dup", first_dup, m_dup);
      end
      if (m_rd_valid) check("rd_data", rd_data, m_rd_exp);
    end
  end

  // Starts a sweep and returns the cycle index at which done was seen (cycle 1 = first after start)
  task automatic run_sweep(input int pulse_at, output int cnt);
    eval_map(p_perm, p_fix, p_dup);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 200) begin
      rd_addr = W'($urandom_range(0, N - 1));
      start   = (cnt == pulse_at);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    if (!done) check("done timeout", 0, 1);
  endtask

  task automatic check_results(input string tag, input int perm, input int fix, input int dup);
    @(negedge clk);
    check({tag, " result_valid"}, result_valid, 1);
    check({tag, " is_perm"}, is_perm, perm);
    check({tag, " fixed_pts"}, fixed_pts, fix);
    check({tag, " first_dup"}, first_dup, dup);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " result_valid"}, result_valid, 0);
    check({tag, " is_perm"}, is_perm, 0);
    check({tag, " fixed_pts"}, fixed_pts, 0);
    check({tag, " first_dup"}, first_dup, 0);
    check({tag, " sb_x"}, sb_x, 0);
    check({tag, " rd_data"}, rd_data, 0);
  endtask

  task automatic random_perm();
    logic [W-1:0] tmp;
    int j;
    for (int i = 0; i < N; i++) map_q[i] = W'(i);
    for (int i = N - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = map_q[i];
      map_q[i] = map_q[j];
      map_q[j] = tmp;
    end
  endtask

  initial begin
    int cnt;
    int done_seen;
    rst     = 1'b1;
    start   = 1'b0;
    rd_addr = {W{1'b0}};
    for (int i = 0; i < N; i++) map_q[i] = W'(i);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_sweep(0, cnt);
    check("identity done cycle", cnt, 65);
    check_results("identity", 1, 64, 0);

    for (int i = 0; i < N; i++) map_q[i] = W'(i) ^ 6'h3F;
    run_sweep(0, cnt);
    check("complement done cycle", cnt, 65);
    check_results("complement", 1, 0, 0);
    rd_addr = 6'd5;
    @(negedge clk);
    check("complement rd_data[5]", rd_data, 8'h3A);

    for (int i = 0; i < N; i++) map_q[i] = 6'h2A;
    run_sweep(0, cnt);
    check_results("constant", 0, 1, 1);

    for (int i = 0; i < N; i++) map_q[i] = W'(i);
    map_q[63] = 6'd0;
    run_sweep(0, cnt);
    check_results("last collides", 0, 63, 63);

    random_perm();
    run_sweep(10, cnt);
    check("restart ignored done cycle", cnt, 65);
    check_results("restart ignored", 1, p_fix, 0);

    for (int i = 0; i < N; i++) map_q[i] = W'($urandom_range(0, N - 1));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("mid-sweep reset");
    @(posedge clk);
    #2 rst = 1'b0;
    done_seen = 0;
    repeat (80) begin
      @(negedge clk);
      rd_addr = W'($urandom_range(0, N - 1));
      if (done) done_seen++;
    end
    check("no done after reset", done_seen, 0);

    for (int i = 0; i < N; i++) map_q[i] = W'($urandom_range(0, 15));
    run_sweep(0, cnt);
    check("post-reset done cycle", cnt, 65);
    check_results("post-reset", p_perm, p_fix, p_dup);

    for (int r = 0; r < 6; r++) begin
      if (r[0]) random_perm();
      else for (int i = 0; i < N; i++) map_q[i] = W'($urandom_range(0, N - 1));
      if (r == 4) map_q[$urandom_range(0, N - 1)] = W'($urandom_range(0, N - 1));
      run_sweep(0, cnt);
      check("random done cycle", cnt, 65);
      check_results("random", p_perm, p_fix, p_dup);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
